// File: rtl/lsb_me_ctrl.sv
// lsb_me_ctrl: initiator-side controller for LSB-first modular exponentiation
// M^E mod N carried out in the Montgomery domain on an external MA engine.
// One MA operation is in flight at a time; the final multiply by 1 converts
// the accumulator back out of the Montgomery domain.
// Optional build macro ME_EARLY_EXIT_EN: stop squaring once no set exponent
// bits remain above the current one.
module lsb_me_ctrl #(
    parameter int WIDTH = 256,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base_i,
    input  logic [WIDTH-1:0] one_i,
    input  logic [WIDTH-1:0] exp_i,
    input  logic [WIDTH-1:0] n_i,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_o,
    output logic             ma_start,
    output logic [WIDTH-1:0] ma_a,
    output logic [WIDTH-1:0] ma_b,
    output logic [WIDTH-1:0] ma_n,
    input  logic [WIDTH-1:0] ma_v,
    input  logic             ma_finish
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BIT,
        ST_MUL_GO,
        ST_MUL_WT,
        ST_SQ_CHK,
        ST_SQ_GO,
        ST_SQ_WT,
        ST_CONV_GO,
        ST_CONV_WT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   s_q, s_d;          // running square of the base
    logic [WIDTH-1:0]   p_q, p_d;          // accumulated product
    logic [WIDTH-1:0]   e_q, e_d;          // exponent, shifted right per bit
    logic [CNT_W-1:0]   i_q, i_d;          // index of the bit being processed
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ma_start_q, ma_start_d;
    logic [WIDTH-1:0]   ma_a_q, ma_a_d;
    logic [WIDTH-1:0]   ma_b_q, ma_b_d;
    logic [WIDTH-1:0]   ma_n_q, ma_n_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic last_bit;
    logic early_exit;

    // The final square would only feed a bit that does not exist, so skip it.
    assign last_bit = (i_q == CNT_W'(WIDTH - 1));

`ifdef ME_EARLY_EXIT_EN
    // No set bits above the current one: remaining squares cannot matter.
    assign early_exit = ~|e_q[WIDTH-1:1];
`else
    assign early_exit = 1'b0;
`endif

    // Next-state and datapath update; MA outputs are set on entry to each *_GO
    // state so they are registered and stay stable through the matching *_WT.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        p_d        = p_q;
        e_d        = e_q;
        i_d        = i_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ma_start_d = 1'b0;
        ma_a_d     = ma_a_q;
        ma_b_d     = ma_b_q;
        ma_n_d     = ma_n_q;
        result_d   = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d     = base_i;
                    p_d     = one_i;
                    e_d     = exp_i;
                    ma_n_d  = n_i;
                    i_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ST_BIT;
                end
            end
            ST_BIT: begin
                if (e_q[0]) begin
                    ma_a_d     = p_q;
                    ma_b_d     = s_q;
                    ma_start_d = 1'b1;
                    state_d    = ST_MUL_GO;
                end else begin
                    state_d = ST_SQ_CHK;
                end
            end
            ST_MUL_GO: state_d = ST_MUL_WT;
            ST_MUL_WT: begin
                if (ma_finish) begin
                    p_d     = ma_v;
                    state_d = ST_SQ_CHK;
                end
            end
            ST_SQ_CHK: begin
                ma_start_d = 1'b1;
                if (last_bit || early_exit) begin
                    ma_a_d  = p_q;
                    ma_b_d  = WIDTH'(1);
                    state_d = ST_CONV_GO;
                end else begin
                    ma_a_d  = s_q;
                    ma_b_d  = s_q;
                    state_d = ST_SQ_GO;
                end
            end
            ST_SQ_GO: state_d = ST_SQ_WT;
            ST_SQ_WT: begin
                if (ma_finish) begin
                    s_d     = ma_v;
                    e_d     = e_q >> 1;
                    i_d     = i_q + 1'b1;
                    state_d = ST_BIT;
                end
            end
            ST_CONV_GO: state_d = ST_CONV_WT;
            ST_CONV_WT: begin
                if (ma_finish) begin
                    result_d = ma_v;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset clears everything back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            p_q        <= '0;
            e_q        <= '0;
            i_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ma_start_q <= 1'b0;
            ma_a_q     <= '0;
            ma_b_q     <= '0;
            ma_n_q     <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            p_q        <= p_d;
            e_q        <= e_d;
            i_q        <= i_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ma_start_q <= ma_start_d;
            ma_a_q     <= ma_a_d;
            ma_b_q     <= ma_b_d;
            ma_n_q     <= ma_n_d;
            result_q   <= result_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result_o = result_q;
    assign ma_start = ma_start_q;
    assign ma_a     = ma_a_q;
    assign ma_b     = ma_b_q;
    assign ma_n     = ma_n_q;

endmodule

// File: tb/tb_lsb_me_ctrl.sv
// Testbench for lsb_me_ctrl at WIDTH=8 with a behavioural Montgomery engine.
module tb_lsb_me_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] base_i = '0, one_i = '0, exp_i = '0, n_i = '0;
    logic         busy, done, ma_start;
    logic [W-1:0] result_o, ma_a, ma_b, ma_n;
    logic [W-1:0] ma_v = '0;
    logic         ma_finish = 1'b0;

    lsb_me_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_i(base_i), .one_i(one_i), .exp_i(exp_i), .n_i(n_i),
        .busy(busy), .done(done), .result_o(result_o),
        .ma_start(ma_start), .ma_a(ma_a), .ma_b(ma_b), .ma_n(ma_n),
        .ma_v(ma_v), .ma_finish(ma_finish)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_res_q[$];
    int exp_cnt_q[$];
    int ma_lat   = 5;
    int ma_cnt   = 0;
    int done_cnt = 0;
    bit pend = 0;
    int cd = 0;
    int cap_a = 0, cap_b = 0, cap_n = 0;
    bit prev_done = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // a*b*2^-8 mod n via an explicit inverse of 256
    function automatic int mont(input int a, input int b, input int n);
        int inv = 0;
        for (int x = 0; x < n; x++) if (((256 * x) % n) == 1) inv = x;
        return (((a * b) % n) * inv) % n;
    endfunction

    function automatic int mpow(input int m, input int e, input int n);
        int r = 1 % n;
        for (int k = 0; k < e; k++) r = (r * m) % n;
        return r;
    endfunction

    function automatic int nstarts(input int e);
        int pc = 0;
        int msb = 0;
        for (int k = 0; k < W; k++) if (((e >> k) & 1) == 1) begin pc++; msb = k; end
`ifdef ME_EARLY_EXIT_EN
        return (e == 0) ? 1 : pc + msb + 1;
`else
        return (W - 1) + pc + 1;
`endif
    endfunction

    // Behavioural MA engine plus handshake/stability monitor
    always @(negedge clk) begin
        bit was_pend;
        if (reset) begin
            pend = 0;
            ma_finish = 1'b0;
        end else begin
            was_pend = pend;
            ma_finish = 1'b0;
            if (pend) begin
                check("busy_during_op", int'(busy), 1);
                check("ma_a_stable", int'(ma_a), cap_a);
                check("ma_b_stable", int'(ma_b), cap_b);
                check("ma_n_stable", int'(ma_n), cap_n);
                cd--;
                if (cd == 0) begin
                    ma_v = W'(mont(cap_a, cap_b, cap_n));
                    ma_finish = 1'b1;
                    pend = 0;
                end
            end
            if (ma_start) begin
                check("no_start_while_outstanding", int'(was_pend), 0);
                ma_cnt++;
                pend = 1;
                cd = ma_lat;
                cap_a = int'(ma_a);
                cap_b = int'(ma_b);
                cap_n = int'(ma_n);
            end
        end
    end

    // Scoreboard monitor: pops an expectation on every done pulse
    always @(negedge clk) begin
        int r, c;
        if (reset) begin
            prev_done = 0;
        end else begin
            if (prev_done) check("done_one_cycle", int'(done), 0);
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", int'(busy), 0);
                if (exp_res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: result_o=%0d with no request pending", result_o);
                end else begin
                    r = exp_res_q.pop_front();
                    c = exp_cnt_q.pop_front();
                    check("result_o", int'(result_o), r);
                    check("ma_start_count", ma_cnt, c);
                end
            end
            prev_done = done;
        end
    end

    task automatic drive_start(input int n, input int m, input int e, input bit track);
        @(posedge clk) #1;
        n_i    = W'(n);
        base_i = W'((m * 256) % n);
        one_i  = W'(256 % n);
        exp_i  = W'(e);
        start  = 1'b1;
        if (track) begin
            exp_res_q.push_back(mpow(m, e, n));
            exp_cnt_q.push_back(nstarts(e));
            ma_cnt = 0;
        end
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 20000) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done after %0d cycles", k);
            exp_res_q.delete();
            exp_cnt_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run_op(input int n, input int m, input int e);
        int d0 = done_cnt;
        drive_start(n, m, e, 1'b1);
        wait_done(d0);
    endtask

    initial begin
        int d0, k, n, m, e;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ma_start", int'(ma_start), 0);
        check("rst_result", int'(result_o), 0);
        check("rst_ma_a", int'(ma_a), 0);
        check("rst_ma_b", int'(ma_b), 0);
        check("rst_ma_n", int'(ma_n), 0);
        @(posedge clk) #1;
        reset = 1'b0;

        // T1..T3 directed
        run_op(13, 2, 5);
        run_op(13, 2, 0);
        run_op(13, 2, 255);

        // T4 long MA latency
        ma_lat = 40;
        run_op(13, 2, 5);
        run_op(251, 77, 8'hA6);
        ma_lat = 5;

        // T5 start while busy is ignored
        d0 = done_cnt;
        drive_start(13, 2, 5, 1'b1);
        repeat (20) @(posedge clk);
        drive_start(11, 7, 200, 1'b0);
        wait_done(d0);

        // T6 reset during a square wait
        drive_start(13, 2, 5, 1'b1);
        k = 0;
        while (ma_cnt < 2 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        check("reached_square", ma_cnt, 2);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        @(negedge clk);
        exp_res_q.delete();
        exp_cnt_q.delete();
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_ma_start", int'(ma_start), 0);
        check("abort_result", int'(result_o), 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle_after_abort", int'(busy), 0);
        run_op(13, 2, 5);

        // Randomized operations
        for (int t = 0; t < 30; t++) begin
            n = 2 * int'($urandom_range(1, 127)) + 1;
            m = int'($urandom_range(0, n - 1));
            e = int'($urandom_range(0, 255));
            if (t == 3) e = 0;
            if (t == 4) e = 255;
            ma_lat = int'($urandom_range(1, 8));
            run_op(n, m, e);
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
